// File: rtl/fifo_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter_if
// Bundles the producer handshake and FIFO write-port signals of the
// round-robin FIFO write arbiter. The _i/_o suffixes are named from the
// arbiter's point of view.
//
//   enable_i       1 = arbiter FSM advances, 0 = FSM and counters hold
//   req_i          per-producer request (level, 4-phase handshake)
//   req_data_i     producer k byte at [k*DATA_W +: DATA_W]
//   ack_o          per-producer acknowledge, one-hot or zero
//   fifo_busy_i    1 = FIFO cannot take a write this cycle
//   fifo_data_o    byte presented to the FIFO, latched at grant time
//   fifo_we_o      one-cycle FIFO write strobe
//   grant_id_o     index of the current or last granted producer
//   busy_timeout_o sticky flag: some grant waited BUSY_TIMEOUT busy cycles
//   write_count_o  total number of write strobes issued (wraps)
//
// Modports: master = producers/FIFO side, slave = arbiter.
// ---------------------------------------------------------------------------
interface fifo_write_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 8,
  parameter int ID_W   = 2
);
  logic                      enable_i;
  logic [N_REQ-1:0]          req_i;
  logic [N_REQ*DATA_W-1:0]   req_data_i;
  logic [N_REQ-1:0]          ack_o;
  logic                      fifo_busy_i;
  logic [DATA_W-1:0]         fifo_data_o;
  logic                      fifo_we_o;
  logic [ID_W-1:0]           grant_id_o;
  logic                      busy_timeout_o;
  logic [15:0]               write_count_o;

  modport master (
    output enable_i, req_i, req_data_i, fifo_busy_i,
    input  ack_o, fifo_data_o, fifo_we_o, grant_id_o, busy_timeout_o,
           write_count_o
  );

  modport slave (
    input  enable_i, req_i, req_data_i, fifo_busy_i,
    output ack_o, fifo_data_o, fifo_we_o, grant_id_o, busy_timeout_o,
           write_count_o
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
// Round-robin arbiter sharing one FIFO write port among N_REQ byte
// producers. A producer is granted in IDLE and its byte is latched. The
// arbiter then waits in WAIT until the FIFO is not busy and issues one
// fifo_we pulse together with ack. It then holds ack in RELEASE until the
// producer drops req. It also counts writes and flags long busy waits.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    fifo_write_arbiter_if.slave (handshake, FIFO port, statistics)
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DATA_W       = 8,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fifo_write_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [15:0]          timer_q, timer_d;
  logic [N_REQ-1:0]     ack_q, ack_d;
  logic                 fifo_we_q, fifo_we_d;
  logic [DATA_W-1:0]    fifo_data_q, fifo_data_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 busy_timeout_q, busy_timeout_d;
  logic [15:0]          write_count_q, write_count_d;

  logic [DATA_W-1:0]    req_byte [N_REQ];
  logic                 pick_valid;
  logic [ID_W-1:0]      pick_idx;

  // (base + off) mod N_REQ, with base < N_REQ and off < N_REQ
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base,
                                               input int unsigned     off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign req_byte[gi] = bus.req_data_i[gi*DATA_W +: DATA_W];
  end

  // The first set request found scanning upward from rr_ptr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!pick_valid && bus.req_i[wrap_idx(rr_ptr_q, i)]) begin
        pick_valid = 1'b1;
        pick_idx   = wrap_idx(rr_ptr_q, i);
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    timer_d        = timer_q;
    ack_d          = ack_q;
    fifo_we_d      = 1'b0;  // strobe self-clears even while enable is low
    fifo_data_d    = fifo_data_q;
    grant_id_d     = grant_id_q;
    busy_timeout_d = busy_timeout_q;
    write_count_d  = write_count_q;

    if (bus.enable_i) begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_id_d  = pick_idx;
            fifo_data_d = req_byte[pick_idx];
            timer_d     = '0;
            state_d     = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!bus.req_i[grant_id_q]) begin
            // Producer withdrew before the write: no write, pointer unchanged
            state_d = ST_IDLE;
          end else if (!bus.fifo_busy_i) begin
            fifo_we_d     = 1'b1;
            ack_d         = {{(N_REQ-1){1'b0}}, 1'b1} << grant_id_q;
            write_count_d = write_count_q + 16'd1;
            state_d       = ST_RELEASE;
          end else begin
            if (timer_q != 16'hFFFF) timer_d = timer_q + 16'd1;
            if (timer_d >= 16'(BUSY_TIMEOUT)) busy_timeout_d = 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!bus.req_i[grant_id_q]) begin
            ack_d    = '0;
            rr_ptr_d = wrap_idx(grant_id_q, 1);  // winner drops to lowest priority
            state_d  = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      rr_ptr_q       <= '0;
      timer_q        <= '0;
      ack_q          <= '0;
      fifo_we_q      <= 1'b0;
      fifo_data_q    <= '0;
      grant_id_q     <= '0;
      busy_timeout_q <= 1'b0;
      write_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      timer_q        <= timer_d;
      ack_q          <= ack_d;
      fifo_we_q      <= fifo_we_d;
      fifo_data_q    <= fifo_data_d;
      grant_id_q     <= grant_id_d;
      busy_timeout_q <= busy_timeout_d;
      write_count_q  <= write_count_d;
    end
  end

  assign bus.ack_o          = ack_q;
  assign bus.fifo_we_o      = fifo_we_q;
  assign bus.fifo_data_o    = fifo_data_q;
  assign bus.grant_id_o     = grant_id_q;
  assign bus.busy_timeout_o = busy_timeout_q;
  assign bus.write_count_o  = write_count_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed scenarios followed by randomized producer traffic, checked against
// a transaction-level model: round-robin pick over the pending set, the byte
// each producer holds, and a running write count.
// ---------------------------------------------------------------------------
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
  localparam int BT = 255;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(N), .DATA_W(DW), .ID_W(IW)) bus ();

  fifo_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ID_W(IW), .BUSY_TIMEOUT(BT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] pdata [N];
  logic [N-1:0]  pending;
  int            model_rr;
  int            model_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_i = pending;
    for (int i = 0; i < N; i++) bus.req_data_i[i*DW +: DW] = pdata[i];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin rule: first pending producer at or above rr, modulo N
  function automatic int pick(input logic [N-1:0] p, input int rr);
    for (int off = 0; off < N; off++) begin
      if (p[(rr + off) % N]) return (rr + off) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    pending = '0;
    for (int i = 0; i < N; i++) pdata[i] = '0;
    apply();
    bus.enable_i = 1'b1;
    bus.fifo_busy_i = 1'b0;
    #3;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check("rst_ack", 32'(bus.ack_o), 0);
    check("rst_we", 32'(bus.fifo_we_o), 0);
    check("rst_data", 32'(bus.fifo_data_o), 0);
    check("rst_grant", 32'(bus.grant_id_o), 0);
    check("rst_bt", 32'(bus.busy_timeout_o), 0);
    check("rst_wc", 32'(bus.write_count_o), 0);
    model_rr = 0;
    model_cnt = 0;
  endtask

  task automatic wait_we(input bit rnd, input int limit, output bit got);
    got = 1'b0;
    for (int c = 0; c < limit && !got; c++) begin
      if (rnd) begin
        bus.enable_i = ($urandom_range(0, 3) != 0);
        bus.fifo_busy_i = ($urandom_range(0, 2) == 0);
      end
      step();
      if (bus.fifo_we_o) got = 1'b1;
    end
    bus.enable_i = 1'b1;
    bus.fifo_busy_i = 1'b0;
    check("we_seen", 32'(got), 1);
  endtask

  // Producer k drops req after its ack; arbiter must clear ack on that edge
  task automatic release_req(input int k);
    pending[k] = 1'b0;
    apply();
    bus.enable_i = 1'b1;
    step();
    check("rel_we", 32'(bus.fifo_we_o), 0);
    check("rel_ack", 32'(bus.ack_o), 0);
    model_rr = (k + 1) % N;
  endtask

  task automatic check_write(input string tag, input int k);
    check({tag, "_grant"}, 32'(bus.grant_id_o), 32'(k));
    check({tag, "_data"}, 32'(bus.fifo_data_o), 32'(pdata[k]));
    check({tag, "_ack"}, 32'(bus.ack_o), 32'(1) << k);
    check({tag, "_wc"}, 32'(bus.write_count_o), 32'(model_cnt));
  endtask

  initial begin
    bit got;
    int k;
    logic [N-1:0] newmask;

    // 1: single request, two-edge latency
    do_reset();
    pdata[2] = 8'hA5;
    pending = 4'b0100;
    apply();
    step();
    check("t1_no_early_we", 32'(bus.fifo_we_o), 0);
    step();
    check("t1_we", 32'(bus.fifo_we_o), 1);
    model_cnt = 1;
    check_write("t1", 2);
    step();
    check("t1_we_one_cycle", 32'(bus.fifo_we_o), 0);
    check("t1_ack_held", 32'(bus.ack_o), 32'h4);
    pending = '0;
    apply();
    step();
    check("t1_ack_drop", 32'(bus.ack_o), 0);
    check("t1_wc", 32'(bus.write_count_o), 1);
    $display("t1 single request done");

    // 2: all four request together
    do_reset();
    for (int i = 0; i < N; i++) pdata[i] = 8'(8'h10 + i);
    pending = 4'b1111;
    apply();
    for (int i = 0; i < N; i++) begin
      wait_we(1'b0, 10, got);
      model_cnt++;
      check_write("t2", i);
      release_req(i);
    end
    check("t2_wc", 32'(bus.write_count_o), 4);
    $display("t2 four-way round robin done");

    // 3: two producers re-raising continuously alternate
    do_reset();
    pdata[0] = 8'h30;
    pdata[3] = 8'h33;
    pending = 4'b1001;
    apply();
    for (int w = 0; w < 8; w++) begin
      k = pick(pending, model_rr);
      wait_we(1'b0, 10, got);
      model_cnt++;
      check("t3_expected_alt", 32'(k), (w % 2 == 0) ? 32'd0 : 32'd3);
      check_write("t3", k);
      release_req(k);
      pending[k] = 1'b1;
      apply();
    end
    $display("t3 alternation done");

    // 4: long busy wait sets sticky busy_timeout
    do_reset();
    pdata[1] = 8'h41;
    pending = 4'b0010;
    bus.fifo_busy_i = 1'b1;
    apply();
    for (int n = 1; n <= 300; n++) begin
      step();
      check("t4_no_we", 32'(bus.fifo_we_o), 0);
      if (n == BT) check("t4_bt_before", 32'(bus.busy_timeout_o), 0);
      if (n == BT + 1) check("t4_bt_set", 32'(bus.busy_timeout_o), 1);
    end
    check("t4_no_ack", 32'(bus.ack_o), 0);
    bus.fifo_busy_i = 1'b0;
    step();
    check("t4_we", 32'(bus.fifo_we_o), 1);
    model_cnt = 1;
    check_write("t4", 1);
    release_req(1);
    check("t4_bt_sticky", 32'(bus.busy_timeout_o), 1);
    $display("t4 busy timeout done");

    // 5: abort in WAIT leaves rr pointer and count untouched
    do_reset();
    pdata[1] = 8'h51;
    pdata[3] = 8'h53;
    pending = 4'b0010;
    bus.fifo_busy_i = 1'b1;
    apply();
    step();
    step();
    pending = '0;
    apply();
    step();
    check("t5_abort_we", 32'(bus.fifo_we_o), 0);
    check("t5_abort_ack", 32'(bus.ack_o), 0);
    bus.fifo_busy_i = 1'b0;
    step();
    check("t5_idle_we", 32'(bus.fifo_we_o), 0);
    check("t5_wc", 32'(bus.write_count_o), 0);
    pending = 4'b1010;
    apply();
    wait_we(1'b0, 10, got);
    model_cnt = 1;
    check_write("t5", 1);
    release_req(1);
    $display("t5 abort done");

    // 6a: async reset while in RELEASE
    do_reset();
    pdata[0] = 8'h61;
    pending = 4'b0001;
    apply();
    wait_we(1'b0, 10, got);
    step();
    check("t6a_ack_pre", 32'(bus.ack_o), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6a_ack", 32'(bus.ack_o), 0);
    check("t6a_we", 32'(bus.fifo_we_o), 0);
    check("t6a_wc", 32'(bus.write_count_o), 0);
    // 6b: async reset on the fifo_we cycle
    do_reset();
    pdata[0] = 8'h62;
    pending = 4'b0001;
    apply();
    wait_we(1'b0, 10, got);
    check("t6b_we_pre", 32'(bus.fifo_we_o), 1);
    rst_n = 1'b0;
    #1;
    check("t6b_we", 32'(bus.fifo_we_o), 0);
    check("t6b_ack", 32'(bus.ack_o), 0);
    check("t6b_wc", 32'(bus.write_count_o), 0);
    $display("t6 async reset done");

    // Randomized producers, random enable and busy
    do_reset();
    for (int r = 0; r < 40; r++) begin
      newmask = 4'($urandom_range(0, 15)) & ~pending;
      if (pending == '0 && newmask == '0) newmask = 4'(1) << $urandom_range(0, N - 1);
      for (int i = 0; i < N; i++) if (newmask[i]) pdata[i] = 8'($urandom);
      pending = pending | newmask;
      apply();
      k = pick(pending, model_rr);
      wait_we(1'b1, 200, got);
      if (got) begin
        model_cnt++;
        check_write("rnd", k);
        check("rnd_bt", 32'(bus.busy_timeout_o), 0);
      end
      $display("rnd round %0d: pending=%b expected grant=%0d got grant=%0d data=%0h",
               r, pending, k, bus.grant_id_o, bus.fifo_data_o);
      release_req(k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
